reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station_pkg.sv | 39 +++
 rtl/reservation_station_pick.sv | 24 ++
 rtl/reservation_station.sv | 156 +++++++++++++++
 tb/tb_reservation_station.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station: datapath widths, default
// station depth, ALU op encodings and the entry record layout.
package reservation_station_pkg;

  localparam int OP_W        = 4;
  localparam int ROB_BIT     = 4;
  localparam int DAT_W       = 32;
  localparam int RAM_ADR_W   = 16;
  localparam int RS_SIZE_DEF = 8;
  localparam int RS_BIT_DEF  = $clog2(RS_SIZE_DEF);

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_ADDI = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_LUI  = 4'd7
  } op_e;

  // One station slot: operation, destination tag and both source operands.
  typedef struct packed {
    logic                 busy;
    logic [OP_W-1:0]      op;
    logic                 ic;
    logic [ROB_BIT-1:0]   qd;
    logic                 rdys;
    logic [ROB_BIT-1:0]   qs;
    logic [DAT_W-1:0]     vs;
    logic                 rdyt;
    logic [ROB_BIT-1:0]   qt;
    logic [DAT_W-1:0]     vt;
    logic [DAT_W-1:0]     imm;
    logic [RAM_ADR_W-1:0] pc;
  } rs_entry_t;

endpackage

// File: rtl/reservation_station_pick.sv
// rs_pick: combinational lowest-index priority encoder.
// Ports:
//   i_vec   - request vector, bit i set means slot i is a candidate
//   o_idx   - index of the lowest set bit (0 when none set)
//   o_found - at least one bit of i_vec is set
module rs_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_found = |i_vec;
    for (int i = N - 1; i >= 0; i--) begin
      o_idx = i_vec[i] ? W'(i) : o_idx;
    end
  end

endmodule

// File: rtl/reservation_station.sv
// reservation_station: holds dispatched ALU operations until both source
// operands are available, captures results from the common data bus, and
// issues the oldest-slot (lowest index) ready entry to the ALU each cycle.
// Ports:
//   clk, rst         - clock, asynchronous active-low reset
//   en               - global enable, low freezes all entries
//   clr_i            - flush all entries (mispredict)
//   dsp_*            - dispatch request with operands/tags
//   full_o           - every slot busy
//   cdb_*            - result broadcast (tag + value)
//   alu_*            - registered issue port to the ALU
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr_i,
  input  logic                 dsp_en_i,
  input  logic [OP_W-1:0]      dsp_op_i,
  input  logic                 dsp_ic_i,
  input  logic [ROB_BIT-1:0]   dsp_qd_i,
  input  logic                 dsp_rdys_i,
  input  logic [ROB_BIT-1:0]   dsp_qs_i,
  input  logic [DAT_W-1:0]     dsp_vs_i,
  input  logic                 dsp_rdyt_i,
  input  logic [ROB_BIT-1:0]   dsp_qt_i,
  input  logic [DAT_W-1:0]     dsp_vt_i,
  input  logic [DAT_W-1:0]     dsp_imm_i,
  input  logic [RAM_ADR_W-1:0] dsp_pc_i,
  output logic                 full_o,
  input  logic                 cdb_en_i,
  input  logic [ROB_BIT-1:0]   cdb_q_i,
  input  logic [DAT_W-1:0]     cdb_v_i,
  output logic                 alu_en_o,
  output logic [OP_W-1:0]      alu_op_o,
  output logic                 alu_ic_o,
  output logic [ROB_BIT-1:0]   alu_qd_o,
  output logic [DAT_W-1:0]     alu_vs_o,
  output logic [DAT_W-1:0]     alu_vt_o,
  output logic [DAT_W-1:0]     alu_imm_o,
  output logic [RAM_ADR_W-1:0] alu_pc_o
);

  localparam int RS_BIT = $clog2(RS_SIZE);

  rs_entry_t          r_ent [RS_SIZE];
  logic [RS_SIZE-1:0] w_busy;
  logic [RS_SIZE-1:0] w_free;
  logic [RS_SIZE-1:0] w_ready;
  logic [RS_BIT-1:0]  w_free_idx;
  logic [RS_BIT-1:0]  w_rdy_idx;
  logic               w_free_found;
  logic               w_rdy_found;
  logic               w_dsp_go;
  logic               w_fwd_s;
  logic               w_fwd_t;

  // Occupancy and readiness vectors, all from registered entry state.
  always_comb begin
    w_busy  = '0;
    w_ready = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_busy[i]  = r_ent[i].busy;
      w_ready[i] = r_ent[i].busy & r_ent[i].rdys & r_ent[i].rdyt;
    end
  end

  assign w_free   = ~w_busy;
  assign full_o   = &w_busy;
  assign w_dsp_go = dsp_en_i & ~full_o & w_free_found;
  // A result broadcast in the dispatch cycle would otherwise be missed.
  assign w_fwd_s  = cdb_en_i & ~dsp_rdys_i & (dsp_qs_i == cdb_q_i);
  assign w_fwd_t  = cdb_en_i & ~dsp_rdyt_i & (dsp_qt_i == cdb_q_i);

  rs_pick #(.N(RS_SIZE), .W(RS_BIT)) u_pick_free (
    .i_vec  (w_free),
    .o_idx  (w_free_idx),
    .o_found(w_free_found)
  );

  rs_pick #(.N(RS_SIZE), .W(RS_BIT)) u_pick_ready (
    .i_vec  (w_ready),
    .o_idx  (w_rdy_idx),
    .o_found(w_rdy_found)
  );

  // Entry state and issue register: flush, wakeup, issue and dispatch.
  // The dispatch slot is non-busy and the issue slot is busy, so the three
  // updates never target the same entry in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        r_ent[i] <= '0;
      end
      alu_en_o  <= 1'b0;
      alu_op_o  <= '0;
      alu_ic_o  <= 1'b0;
      alu_qd_o  <= '0;
      alu_vs_o  <= '0;
      alu_vt_o  <= '0;
      alu_imm_o <= '0;
      alu_pc_o  <= '0;
    end else if (en) begin
      if (clr_i) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          r_ent[i].busy <= 1'b0;
        end
        alu_en_o <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (cdb_en_i && r_ent[i].busy && !r_ent[i].rdys && (r_ent[i].qs == cdb_q_i)) begin
            r_ent[i].rdys <= 1'b1;
            r_ent[i].vs   <= cdb_v_i;
          end
          if (cdb_en_i && r_ent[i].busy && !r_ent[i].rdyt && (r_ent[i].qt == cdb_q_i)) begin
            r_ent[i].rdyt <= 1'b1;
            r_ent[i].vt   <= cdb_v_i;
          end
        end
        if (w_rdy_found) begin
          alu_en_o               <= 1'b1;
          alu_op_o               <= r_ent[w_rdy_idx].op;
          alu_ic_o               <= r_ent[w_rdy_idx].ic;
          alu_qd_o               <= r_ent[w_rdy_idx].qd;
          alu_vs_o               <= r_ent[w_rdy_idx].vs;
          alu_vt_o               <= r_ent[w_rdy_idx].vt;
          alu_imm_o              <= r_ent[w_rdy_idx].imm;
          alu_pc_o               <= r_ent[w_rdy_idx].pc;
          r_ent[w_rdy_idx].busy  <= 1'b0;
        end else begin
          alu_en_o <= 1'b0;
        end
        if (w_dsp_go) begin
          r_ent[w_free_idx].busy <= 1'b1;
          r_ent[w_free_idx].op   <= dsp_op_i;
          r_ent[w_free_idx].ic   <= dsp_ic_i;
          r_ent[w_free_idx].qd   <= dsp_qd_i;
          r_ent[w_free_idx].qs   <= dsp_qs_i;
          r_ent[w_free_idx].rdys <= dsp_rdys_i | w_fwd_s;
          r_ent[w_free_idx].vs   <= w_fwd_s ? cdb_v_i : dsp_vs_i;
          r_ent[w_free_idx].qt   <= dsp_qt_i;
          r_ent[w_free_idx].rdyt <= dsp_rdyt_i | w_fwd_t;
          r_ent[w_free_idx].vt   <= w_fwd_t ? cdb_v_i : dsp_vt_i;
          r_ent[w_free_idx].imm  <= dsp_imm_i;
          r_ent[w_free_idx].pc   <= dsp_pc_i;
        end
      end
    end else begin
      alu_en_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed, table-driven bench for reservation_station. Each vector drives
// one cycle of inputs and lists the outputs expected just after that edge.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 clr_i;
  logic                 dsp_en_i;
  logic [OP_W-1:0]      dsp_op_i;
  logic                 dsp_ic_i;
  logic [ROB_BIT-1:0]   dsp_qd_i;
  logic                 dsp_rdys_i;
  logic [ROB_BIT-1:0]   dsp_qs_i;
  logic [DAT_W-1:0]     dsp_vs_i;
  logic                 dsp_rdyt_i;
  logic [ROB_BIT-1:0]   dsp_qt_i;
  logic [DAT_W-1:0]     dsp_vt_i;
  logic [DAT_W-1:0]     dsp_imm_i;
  logic [RAM_ADR_W-1:0] dsp_pc_i;
  logic                 full_o;
  logic                 cdb_en_i;
  logic [ROB_BIT-1:0]   cdb_q_i;
  logic [DAT_W-1:0]     cdb_v_i;
  logic                 alu_en_o;
  logic [OP_W-1:0]      alu_op_o;
  logic                 alu_ic_o;
  logic [ROB_BIT-1:0]   alu_qd_o;
  logic [DAT_W-1:0]     alu_vs_o;
  logic [DAT_W-1:0]     alu_vt_o;
  logic [DAT_W-1:0]     alu_imm_o;
  logic [RAM_ADR_W-1:0] alu_pc_o;

  int n_checks = 0;
  int n_errors = 0;

  reservation_station dut (
    .clk(clk), .rst(rst), .en(en), .clr_i(clr_i),
    .dsp_en_i(dsp_en_i), .dsp_op_i(dsp_op_i), .dsp_ic_i(dsp_ic_i), .dsp_qd_i(dsp_qd_i),
    .dsp_rdys_i(dsp_rdys_i), .dsp_qs_i(dsp_qs_i), .dsp_vs_i(dsp_vs_i),
    .dsp_rdyt_i(dsp_rdyt_i), .dsp_qt_i(dsp_qt_i), .dsp_vt_i(dsp_vt_i),
    .dsp_imm_i(dsp_imm_i), .dsp_pc_i(dsp_pc_i), .full_o(full_o),
    .cdb_en_i(cdb_en_i), .cdb_q_i(cdb_q_i), .cdb_v_i(cdb_v_i),
    .alu_en_o(alu_en_o), .alu_op_o(alu_op_o), .alu_ic_o(alu_ic_o), .alu_qd_o(alu_qd_o),
    .alu_vs_o(alu_vs_o), .alu_vt_o(alu_vt_o), .alu_imm_o(alu_imm_o), .alu_pc_o(alu_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dsp_en;
    logic [3:0]  op;
    logic [3:0]  qd;
    logic        rdys;
    logic [3:0]  qs;
    logic [31:0] vs;
    logic        rdyt;
    logic [3:0]  qt;
    logic [31:0] vt;
    logic        cdb_en;
    logic [3:0]  cdb_q;
    logic [31:0] cdb_v;
    logic        clr;
    logic        e_en;
    logic [3:0]  e_op;
    logic [3:0]  e_qd;
    logic [31:0] e_vs;
    logic [31:0] e_vt;
    logic        e_full;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t idle();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t dv(logic [3:0] op, logic [3:0] qd, logic rs, logic [3:0] qs,
                              logic [31:0] vs, logic rt, logic [3:0] qt, logic [31:0] vt);
    vec_t v;
    v = idle();
    v.dsp_en = 1'b1; v.op = op; v.qd = qd;
    v.rdys = rs; v.qs = qs; v.vs = vs;
    v.rdyt = rt; v.qt = qt; v.vt = vt;
    return v;
  endfunction

  function automatic vec_t wc(vec_t vin, logic [3:0] q, logic [31:0] val);
    vec_t v;
    v = vin;
    v.cdb_en = 1'b1; v.cdb_q = q; v.cdb_v = val;
    return v;
  endfunction

  function automatic vec_t ex(vec_t vin, logic ee, logic [3:0] eop, logic [3:0] eqd,
                              logic [31:0] evs, logic [31:0] evt, logic ef);
    vec_t v;
    v = vin;
    v.e_en = ee; v.e_op = eop; v.e_qd = eqd; v.e_vs = evs; v.e_vt = evt; v.e_full = ef;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // imm, pc and ic are derived from the destination tag so issue can be checked.
  task automatic drive(vec_t v);
    dsp_en_i   = v.dsp_en;
    dsp_op_i   = v.op;
    dsp_ic_i   = v.qd[0];
    dsp_qd_i   = v.qd;
    dsp_rdys_i = v.rdys;
    dsp_qs_i   = v.qs;
    dsp_vs_i   = v.vs;
    dsp_rdyt_i = v.rdyt;
    dsp_qt_i   = v.qt;
    dsp_vt_i   = v.vt;
    dsp_imm_i  = 32'h0000_0100 + {28'h0, v.qd};
    dsp_pc_i   = 16'h4000 + {12'h0, v.qd};
    cdb_en_i   = v.cdb_en;
    cdb_q_i    = v.cdb_q;
    cdb_v_i    = v.cdb_v;
    clr_i      = v.clr;
  endtask

  task automatic run(string tag, vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    chk({tag, ".alu_en"}, {31'h0, alu_en_o}, {31'h0, v.e_en});
    chk({tag, ".full"}, {31'h0, full_o}, {31'h0, v.e_full});
    if (v.e_en) begin
      chk({tag, ".op"}, {28'h0, alu_op_o}, {28'h0, v.e_op});
      chk({tag, ".qd"}, {28'h0, alu_qd_o}, {28'h0, v.e_qd});
      chk({tag, ".vs"}, alu_vs_o, v.e_vs);
      chk({tag, ".vt"}, alu_vt_o, v.e_vt);
      chk({tag, ".imm"}, alu_imm_o, 32'h0000_0100 + {28'h0, v.e_qd});
      chk({tag, ".pc"}, {16'h0, alu_pc_o}, {16'h0, 16'h4000 + {12'h0, v.e_qd}});
      chk({tag, ".ic"}, {31'h0, alu_ic_o}, {31'h0, v.e_qd[0]});
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b0;
    en  = 1'b1;
    drive(idle());

    repeat (2) @(posedge clk);
    #1;
    chk("rst.alu_en", {31'h0, alu_en_o}, 32'h0);
    chk("rst.full", {31'h0, full_o}, 32'h0);
    chk("rst.qd", {28'h0, alu_qd_o}, 32'h0);
    chk("rst.vs", alu_vs_o, 32'h0);
    rst = 1'b1;

    // Main table: latency, two-source wakeup, forwarding, concurrency, tag match.
    tbl.push_back(ex(dv(OP_ADDI, 4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd0), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(ex(idle(), 1'b1, OP_ADDI, 4'd3, 32'd5, 32'd0, 1'b0));
    tbl.push_back(ex(dv(OP_ADD, 4'd1, 1'b0, 4'd2, 32'd0, 1'b0, 4'd4, 32'd0), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(ex(wc(idle(), 4'd2, 32'd10), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(ex(wc(idle(), 4'd4, 32'd7), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(ex(idle(), 1'b1, OP_ADD, 4'd1, 32'd10, 32'd7, 1'b0));
    tbl.push_back(ex(idle(), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(ex(wc(dv(OP_SUB, 4'd5, 1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'd3), 4'd6, 32'hFFFF_FFFF), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(ex(idle(), 1'b1, OP_SUB, 4'd5, 32'hFFFF_FFFF, 32'd3, 1'b0));
    tbl.push_back(ex(idle(), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(ex(dv(OP_ADD, 4'd8, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd4), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(ex(wc(dv(OP_ADD, 4'd7, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2), 4'd9, 32'd11), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(ex(idle(), 1'b1, OP_ADD, 4'd8, 32'd11, 32'd4, 1'b0));
    tbl.push_back(ex(dv(OP_AND, 4'd2, 1'b1, 4'd0, 32'd20, 1'b1, 4'd0, 32'd21), 1'b1, OP_ADD, 4'd7, 32'd1, 32'd2, 1'b0));
    tbl.push_back(ex(idle(), 1'b1, OP_AND, 4'd2, 32'd20, 32'd21, 1'b0));
    tbl.push_back(ex(idle(), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(ex(dv(OP_OR, 4'd4, 1'b0, 4'd3, 32'd0, 1'b1, 4'd0, 32'd6), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(ex(wc(idle(), 4'd11, 32'd99), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(ex(idle(), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(ex(wc(idle(), 4'd3, 32'd33), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(ex(idle(), 1'b1, OP_OR, 4'd4, 32'd33, 32'd6, 1'b0));
    tbl.push_back(ex(idle(), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      run($sformatf("tbl%0d", i), tbl[i]);
    end

    // Enable low: dispatch is not captured and the issue port holds.
    en = 1'b0;
    run("en_low", ex(dv(OP_ADD, 4'd9, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    chk("en_low.hold_qd", {28'h0, alu_qd_o}, 32'd4);
    en = 1'b1;
    run("en_low.after", ex(idle(), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));

    // Fill all slots with waiting entries, then overflow, then free one.
    for (int k = 0; k < 8; k++) begin
      run($sformatf("fill%0d", k),
          ex(dv(OP_ADD, 4'(k), 1'b0, 4'(k), 32'd0, 1'b1, 4'd0, 32'(k)), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, (k == 7)));
    end
    run("fill9", ex(dv(OP_XOR, 4'd15, 1'b1, 4'd0, 32'd9, 1'b1, 4'd0, 32'd9), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b1));
    run("fill9.drop", ex(idle(), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b1));
    run("fill.wake", ex(wc(idle(), 4'd5, 32'd55), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b1));
    run("fill.issue", ex(idle(), 1'b1, OP_ADD, 4'd5, 32'd55, 32'd5, 1'b0));
    v = idle(); v.clr = 1'b1;
    run("fill.clr", ex(v, 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));

    // Flush with four ready entries pending and a concurrent dispatch.
    for (int k = 1; k <= 4; k++) begin
      run($sformatf("fl_dsp%0d", k),
          ex(dv(OP_SUB, 4'(k), 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd1), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    end
    run("fl_wake", ex(wc(idle(), 4'd9, 32'd90), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    v = dv(OP_ADD, 4'd12, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1); v.clr = 1'b1;
    run("fl_clr", ex(v, 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      run($sformatf("fl_after%0d", k), ex(idle(), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    end

    // Asynchronous reset between edges with three waiting entries.
    run("ar_dsp", ex(dv(OP_ADD, 4'd6, 1'b1, 4'd0, 32'd66, 1'b1, 4'd0, 32'd1), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    run("ar_iss", ex(dv(OP_ADD, 4'd1, 1'b0, 4'd13, 32'd0, 1'b1, 4'd0, 32'd1), 1'b1, OP_ADD, 4'd6, 32'd66, 32'd1, 1'b0));
    run("ar_w2", ex(dv(OP_ADD, 4'd2, 1'b0, 4'd13, 32'd0, 1'b1, 4'd0, 32'd1), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    run("ar_w3", ex(dv(OP_ADD, 4'd3, 1'b0, 4'd13, 32'd0, 1'b1, 4'd0, 32'd1), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    drive(idle());
    #2;
    rst = 1'b0;
    #1;
    chk("ar.alu_en", {31'h0, alu_en_o}, 32'h0);
    chk("ar.qd", {28'h0, alu_qd_o}, 32'h0);
    chk("ar.vs", alu_vs_o, 32'h0);
    chk("ar.vt", alu_vt_o, 32'h0);
    chk("ar.imm", alu_imm_o, 32'h0);
    chk("ar.pc", {16'h0, alu_pc_o}, 32'h0);
    chk("ar.op", {28'h0, alu_op_o}, 32'h0);
    #2;
    rst = 1'b1;
    run("ar_cdb", ex(wc(idle(), 4'd13, 32'd130), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    run("ar_idle", ex(idle(), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    run("ar_new", ex(dv(OP_LUI, 4'd10, 1'b1, 4'd0, 32'd100, 1'b1, 4'd0, 32'd101), 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    run("ar_new.iss", ex(idle(), 1'b1, OP_LUI, 4'd10, 32'd100, 32'd101, 1'b0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
